// File: rtl/addsub_acc_pkg.sv
// -----------------------------------------------------------------------------
// addsub_acc_pkg
//   Shared types and helpers for the add/sub result accumulator.
//   - state_t   : frame FSM states (IDLE, ACC, OUT)
//   - RES_W     : width of the add/sub core result (4)
//   - ACC_W_DEF : default accumulator width (8)
//   - ext_res() : interprets a core result as a signed value according to the
//                 opt bit used to produce it (opt=0 unsigned 0..14, opt=1
//                 two's-complement -7..7) and returns it sign-correctly widened.
// -----------------------------------------------------------------------------
package addsub_acc_pkg;

   localparam int RES_W     = 4;
   localparam int ACC_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // opt=0 results are unsigned, so the top bit must not be treated as a sign.
   function automatic logic signed [ACC_W_DEF-1:0] ext_res(
      input logic [RES_W-1:0] res,
      input logic             opt
   );
      logic sgn;
      sgn = opt & res[RES_W-1];
      return {{(ACC_W_DEF-RES_W){sgn}}, res};
   endfunction

endpackage

// File: rtl/addsub_acc_sat.sv
// -----------------------------------------------------------------------------
// addsub_acc_sat
//   Combinational accumulator adder with signed overflow detection and an
//   optional clamp.
//   Build option: ACC_SAT_EN -- when defined, an overflowing sum clamps to the
//   most positive / most negative ACC_W-bit value; otherwise it wraps.
// Ports
//   acc     in   ACC_W  current accumulator (two's complement)
//   addend  in   ACC_W  extended core result (two's complement)
//   sum     out  ACC_W  acc + addend (wrapped or clamped)
//   ovf     out  1      signed overflow of acc + addend
// -----------------------------------------------------------------------------
module addsub_acc_sat #(
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W-1:0] raw_sum;

   assign raw_sum = acc + addend;

   // Overflow only when both operands share a sign and the result flips it.
   assign ovf = (acc[ACC_W-1] == addend[ACC_W-1]) &&
                (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef ACC_SAT_EN
   localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   // On overflow both operands had acc's sign, so acc's sign picks the rail.
   always_comb begin
      sum = raw_sum;
      if (ovf) begin
         sum = acc[ACC_W-1] ? MIN_NEG : MAX_POS;
      end
   end
`else
   assign sum = raw_sum;
`endif

endmodule

// File: rtl/addsub_result_acc.sv
// -----------------------------------------------------------------------------
// addsub_result_acc
//   Consumes 4-bit add/sub core results, accumulates their correctly
//   interpreted signed values per frame and emits sum / count / overflow as a
//   one-cycle pulse after the frame closes (in_last or MAX_LEN results).
//   Build option: ACC_SAT_EN (see addsub_acc_sat) selects clamping instead of
//   wrapping on overflow.
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      input accepted this cycle (low only in OUT)
//   in_res     in   4      core result
//   in_opt     in   1      opt used by the core (0=add, 1=sub)
//   in_last    in   1      beat closes the frame
//   out_valid  out  1      one-cycle frame result pulse
//   out_sum    out  ACC_W  frame sum (0 when out_valid=0)
//   out_cnt    out  CNT_W  results in frame (0 when out_valid=0)
//   out_ovf    out  1      overflow seen in frame (0 when out_valid=0)
// -----------------------------------------------------------------------------
module addsub_result_acc
   import addsub_acc_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] in_res,
   input  logic             in_opt,
   input  logic             in_last,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ovf_reg, ovf_next;

   logic             out_valid_reg, out_valid_next;
   logic [ACC_W-1:0] out_sum_reg, out_sum_next;
   logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
   logic             out_ovf_reg, out_ovf_next;

   logic             accept;
   logic [ACC_W-1:0] ext_val;
   logic [ACC_W-1:0] sat_sum;
   logic             sat_ovf;
   logic [CNT_W-1:0] cnt_inc;
   logic             close_first;
   logic             close_acc;

   // Signed cast keeps the sign extension when ACC_W differs from the default.
   assign ext_val = ACC_W'(ext_res(in_res, in_opt));

   addsub_acc_sat #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc    (acc_reg),
      .addend (ext_val),
      .sum    (sat_sum),
      .ovf    (sat_ovf)
   );

   assign in_ready    = (state_reg != OUT);
   assign accept      = in_valid && in_ready;
   assign cnt_inc     = cnt_reg + CNT_W'(1);
   assign close_first = in_last || (MAX_LEN == 1);
   assign close_acc   = in_last || (cnt_inc == CNT_W'(MAX_LEN));

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               acc_next   = ext_val;
               cnt_next   = CNT_W'(1);
               ovf_next   = 1'b0;
               state_next = close_first ? OUT : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_next   = sat_sum;
               cnt_next   = cnt_inc;
               ovf_next   = ovf_reg | sat_ovf;
               state_next = close_acc ? OUT : ACC;
            end
         end
         OUT: begin
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            state_next = IDLE;
         end
         default: begin
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            state_next = IDLE;
         end
      endcase

      // Result registers load together with the transition into OUT so the
      // outputs are flop-driven and already zero outside the pulse.
      out_valid_next = (state_next == OUT);
      out_sum_next   = out_valid_next ? acc_next : '0;
      out_cnt_next   = out_valid_next ? cnt_next : '0;
      out_ovf_next   = out_valid_next & ovf_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         out_sum_reg   <= '0;
         out_cnt_reg   <= '0;
         out_ovf_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         ovf_reg       <= ovf_next;
         out_valid_reg <= out_valid_next;
         out_sum_reg   <= out_sum_next;
         out_cnt_reg   <= out_cnt_next;
         out_ovf_reg   <= out_ovf_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_sum   = out_sum_reg;
   assign out_cnt   = out_cnt_reg;
   assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_addsub_result_acc.sv
// -----------------------------------------------------------------------------
// tb_addsub_result_acc
//   Directed bench for addsub_result_acc. Expected frame results are pushed to
//   a scoreboard queue when the closing beat is driven; a negedge monitor pops
//   and compares whenever out_valid pulses and checks idle outputs are zero.
//   Honors ACC_SAT_EN for the overflow frame expectation.
// -----------------------------------------------------------------------------
module tb_addsub_result_acc;

   localparam int ACC_W = 8;
   localparam int CNT_W = 5;

   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_res;
   logic             in_opt;
   logic             in_last;
   logic             out_valid;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   addsub_result_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_opt    (in_opt),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one beat starting at a negedge, holds it until accepted.
   task automatic send(input logic [3:0] r, input logic o, input logic l);
      int waitc;
      waitc = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_res   = r;
      in_opt   = o;
      in_last  = l;
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (waitc >= 20) chk("send_timeout", 32'(waitc), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic push(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic v);
      exp_t e;
      e.sum = s;
      e.cnt = c;
      e.ovf = v;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
      chk("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: compare every frame pulse against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_frame", {out_sum, out_cnt, out_ovf}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("[TB] frame sum=%h cnt=%0d ovf=%0d (exp sum=%h cnt=%0d ovf=%0d)",
                        out_sum, out_cnt, out_ovf, e.sum, e.cnt, e.ovf);
               chk("frame_sum", 32'(out_sum), 32'(e.sum));
               chk("frame_cnt", 32'(out_cnt), 32'(e.cnt));
               chk("frame_ovf", 32'(out_ovf), 32'(e.ovf));
            end
         end else begin
            chk("idle_outputs_zero", {out_sum, out_cnt, out_ovf}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_res   = '0;
      in_opt   = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", {out_sum, out_cnt, out_ovf}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: unsigned add results
      send(4'd5, 1'b0, 1'b0);
      send(4'd3, 1'b0, 1'b1);
      push(8'h08, 5'd2, 1'b0);
      drain();

      // 2: signed results (-3 + 2)
      send(4'b1101, 1'b1, 1'b0);
      send(4'b0010, 1'b1, 1'b1);
      push(8'hFF, 5'd2, 1'b0);
      drain();

      // 3: auto-close at MAX_LEN
      for (int i = 0; i < 16; i++) send(4'd1, 1'b0, 1'b0);
      push(8'h10, 5'd16, 1'b0);
      drain();

      // 4: positive overflow
      for (int i = 0; i < 10; i++) send(4'd14, 1'b0, (i == 9));
`ifdef ACC_SAT_EN
      push(8'h7F, 5'd10, 1'b1);
`else
      push(8'h8C, 5'd10, 1'b1);
`endif
      drain();

      // opt decides interpretation of the same bits: 8 + (-8) + (-1)
      send(4'b1000, 1'b0, 1'b0);
      send(4'b1000, 1'b1, 1'b0);
      send(4'b1111, 1'b1, 1'b1);
      push(8'hFF, 5'd3, 1'b0);
      drain();

      // 16 x -8 lands exactly on the negative limit without overflow
      for (int i = 0; i < 16; i++) send(4'b1000, 1'b1, 1'b0);
      push(8'h80, 5'd16, 1'b0);
      drain();

      // 5: reset mid-frame discards the partial frame
      send(4'd1, 1'b0, 1'b0);
      send(4'd2, 1'b0, 1'b0);
      send(4'd3, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {out_valid, out_sum, out_cnt, out_ovf}, 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      send(4'd2, 1'b0, 1'b1);
      push(8'h02, 5'd1, 1'b0);
      drain();

      // 6: input held through OUT is not taken until IDLE
      send(4'd1, 1'b0, 1'b1);
      push(8'h01, 5'd1, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_res   = 4'd4;
      in_opt   = 1'b0;
      in_last  = 1'b1;
      chk("out_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("idle_in_ready_high", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      push(8'h04, 5'd1, 1'b0);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
